// File: rtl/nd_1ton_router.sv
// nd_1ton_router: routes 4-phase req/ack messages from one input channel to one of
// NOUT output channels by destination-address range, with a message FIFO per output.
module nd_1ton_router #(
    parameter int NOUT  = 2,
    parameter int ASZ   = 6,
    parameter int DSZ   = 4,
    parameter int RSZ   = 4,
    parameter int DEPTH = 4,
    parameter logic [NOUT*ASZ-1:0] LO_VEC = '0,
    parameter logic [NOUT*ASZ-1:0] HI_VEC = '1
) (
    input  logic                i_clk,
    input  logic                reset,
    output logic                ready,
    input  logic [ASZ-1:0]      rcv0_src,
    input  logic [ASZ-1:0]      rcv0_dst,
    input  logic [DSZ-1:0]      rcv0_dat,
    input  logic [RSZ-1:0]      rcv0_red,
    input  logic                rcv0_req,
    output logic                rcv0_ack,
    output logic [NOUT*ASZ-1:0] snd_src,
    output logic [NOUT*ASZ-1:0] snd_dst,
    output logic [NOUT*DSZ-1:0] snd_dat,
    output logic [NOUT*RSZ-1:0] snd_red,
    output logic [NOUT-1:0]     snd_req,
    input  logic [NOUT-1:0]     snd_ack,
    output logic [NOUT-1:0]     fifo_full,
    output logic [7:0]          drop_cnt,
    output logic                err_drop
);
    localparam int MW = 2*ASZ + DSZ + RSZ;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (NOUT > 1) ? $clog2(NOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    logic [MW-1:0] in_msg;
    logic          match_any;
    logic [SW-1:0] sel;
    logic          accept;

    assign in_msg = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign accept = ready && rcv0_req && !rcv0_ack;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        match_any = 1'b0;
        sel       = '0;
        // Scan downwards so the lowest matching index is the one left in sel.
        for (int k = NOUT - 1; k >= 0; k--) begin
            if ((rcv0_dst >= LO_VEC[k*ASZ +: ASZ]) && (rcv0_dst <= HI_VEC[k*ASZ +: ASZ])) begin
                match_any = 1'b1;
                sel       = SW'(k);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            ready    <= 1'b0;
            rcv0_ack <= 1'b0;
            drop_cnt <= 8'd0;
            err_drop <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (accept) begin
                if (!match_any) begin
                    rcv0_ack <= 1'b1;
                    err_drop <= 1'b1;
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end else if (!fifo_full[sel]) begin
                    rcv0_ack <= 1'b1;
                end
            end else if (ready && !rcv0_req && rcv0_ack) begin
                rcv0_ack <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_out
        logic [MW-1:0] mem [DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] count;
        logic [MW-1:0] msg;
        logic          req;
        state_t        state;
        logic          push;
        logic          pop;

        assign push         = accept && match_any && (sel == SW'(k)) && !fifo_full[k];
        assign pop          = ready && (state == S_IDLE) && (count != '0);
        assign fifo_full[k] = (count == CW'(DEPTH));

        // NOTE: storage is not reset; count and pointers alone define which entries are valid.
        always_ff @(posedge i_clk) begin
            if (push) mem[wr_ptr] <= in_msg;
        end

        always_ff @(posedge i_clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                msg    <= '0;
                req    <= 1'b0;
                state  <= S_IDLE;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (ready) begin
                    case (state)
                        S_IDLE: if (pop) begin
                            msg   <= mem[rd_ptr];
                            req   <= 1'b1;
                            state <= S_REQ;
                        end
                        S_REQ: if (snd_ack[k]) begin
                            req   <= 1'b0;
                            state <= S_WAIT;
                        end
                        S_WAIT: if (!snd_ack[k]) state <= S_IDLE;
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end

        assign snd_src[k*ASZ +: ASZ] = msg[MW-1 -: ASZ];
        assign snd_dst[k*ASZ +: ASZ] = msg[DSZ+RSZ +: ASZ];
        assign snd_dat[k*DSZ +: DSZ] = msg[RSZ +: DSZ];
        assign snd_red[k*RSZ +: RSZ] = msg[RSZ-1:0];
        assign snd_req[k]            = req;
    end
endmodule

// File: tb/tb_nd_1ton_router.sv
// Bench for nd_1ton_router: output 0 covers dst 0..31, output 1 covers dst 0..50
// (overlap exercises lowest-index priority), dst 51..63 is unroutable.
module tb_nd_1ton_router;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready;
    logic [5:0]  rcv0_src = '0;
    logic [5:0]  rcv0_dst = '0;
    logic [3:0]  rcv0_dat = '0;
    logic [3:0]  rcv0_red = '0;
    logic        rcv0_req = 1'b0;
    logic        rcv0_ack;
    logic [11:0] snd_src;
    logic [11:0] snd_dst;
    logic [7:0]  snd_dat;
    logic [7:0]  snd_red;
    logic [1:0]  snd_req;
    logic [1:0]  snd_ack = '0;
    logic [1:0]  fifo_full;
    logic [7:0]  drop_cnt;
    logic        err_drop;

    int total = 0;
    int bad = 0;
    int exp_drops = 0;
    int max_dly = 0;
    logic [1:0]  hold = '0;
    logic [1:0]  seen = '0;
    int          dly [2];
    logic [19:0] cap [2];
    logic [19:0] cons_got;
    logic [19:0] cons_exp;
    logic [19:0] exp_q0 [$];
    logic [19:0] exp_q1 [$];

    nd_1ton_router #(
        .NOUT(2), .ASZ(6), .DSZ(4), .RSZ(4), .DEPTH(4),
        .LO_VEC({6'd0, 6'd0}),
        .HI_VEC({6'd50, 6'd31})
    ) dut (
        .i_clk(clk), .reset(reset), .ready(ready),
        .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red),
        .rcv0_req(rcv0_req), .rcv0_ack(rcv0_ack),
        .snd_src(snd_src), .snd_dst(snd_dst), .snd_dat(snd_dat), .snd_red(snd_red),
        .snd_req(snd_req), .snd_ack(snd_ack),
        .fifo_full(fifo_full), .drop_cnt(drop_cnt), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    function automatic int route(input logic [5:0] d);
        if (d <= 6'd31) return 0;
        if (d <= 6'd50) return 1;
        return -1;
    endfunction

    function automatic logic [19:0] out_msg(input int k);
        return {snd_src[k*6 +: 6], snd_dst[k*6 +: 6], snd_dat[k*4 +: 4], snd_red[k*4 +: 4]};
    endfunction

    // Output-side consumer: checks each delivered message against the scoreboard,
    // then completes the 4-phase handshake after a random delay unless held.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                snd_ack[k] = 1'b0;
                seen[k]    = 1'b0;
            end else if (snd_ack[k]) begin
                if (!snd_req[k]) snd_ack[k] = 1'b0;
            end else if (snd_req[k]) begin
                if (!seen[k]) begin
                    cons_got = out_msg(k);
                    cap[k]   = cons_got;
                    seen[k]  = 1'b1;
                    dly[k]   = $urandom_range(0, max_dly);
                    total++;
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        bad++;
                        $display("FAIL out%0d_unexpected: got msg %h, required no delivery", k, cons_got);
                    end else begin
                        if (k == 0) cons_exp = exp_q0.pop_front();
                        else        cons_exp = exp_q1.pop_front();
                        if (cons_got !== cons_exp) begin
                            bad++;
                            $display("FAIL out%0d_data: got %h, required %h", k, cons_got, cons_exp);
                        end
                    end
                end else if (!hold[k]) begin
                    if (dly[k] == 0) begin
                        total++;
                        if (out_msg(k) !== cap[k]) begin
                            bad++;
                            $display("FAIL out%0d_stable: got %h, required %h", k, out_msg(k), cap[k]);
                        end
                        snd_ack[k] = 1'b1;
                        seen[k]    = 1'b0;
                    end else begin
                        dly[k]--;
                    end
                end
            end
        end
    end

    task automatic record(input logic [19:0] m);
        int r;
        r = route(m[13:8]);
        if (r == 0)      exp_q0.push_back(m);
        else if (r == 1) exp_q1.push_back(m);
        else             exp_drops++;
    endtask

    task automatic put_req(input logic [5:0] s, input logic [5:0] d, input logic [3:0] a, input logic [3:0] r);
        @(negedge clk);
        rcv0_src = s;
        rcv0_dst = d;
        rcv0_dat = a;
        rcv0_red = r;
        rcv0_req = 1'b1;
    endtask

    task automatic finish_req(input int bound);
        int n;
        n = 0;
        while (!rcv0_ack && n < bound) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!rcv0_ack) begin
            bad++;
            $display("FAIL input_ack: ack=0 after %0d cycles, required 1", bound);
            rcv0_req = 1'b0;
            return;
        end
        record({rcv0_src, rcv0_dst, rcv0_dat, rcv0_red});
        rcv0_req = 1'b0;
        n = 0;
        while (rcv0_ack && n < bound) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rcv0_ack) begin
            bad++;
            $display("FAIL input_release: ack=1 after %0d cycles, required 0", bound);
        end
    endtask

    task automatic send(input logic [5:0] s, input logic [5:0] d, input logic [3:0] a, input logic [3:0] r);
        put_req(s, d, a, r);
        finish_req(40);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || snd_req != 2'b00 || snd_ack != 2'b00) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 1000) begin
            bad++;
            $display("FAIL drain: pending out0=%0d out1=%0d req=%b, required 0 0 00",
                     exp_q0.size(), exp_q1.size(), snd_req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({ready, rcv0_ack, snd_req, fifo_full, drop_cnt, err_drop} !== 15'd0 ||
            {snd_src, snd_dst, snd_dat, snd_red} !== 40'd0) begin
            bad++;
            $display("FAIL %s: ready=%b ack=%b req=%b full=%b drop=%0d err=%b fields=%h, required all 0",
                     tag, ready, rcv0_ack, snd_req, fifo_full, drop_cnt, err_drop,
                     {snd_src, snd_dst, snd_dat, snd_red});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge: got %b, required 0", ready);
        end
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_rise: got %b, required 1", ready);
        end
    endtask

    task automatic test_basic();
        max_dly = 1;
        send(6'd1, 6'd5, 4'd3, 4'd7);
        total++;
        if (snd_req !== 2'b01) begin
            bad++;
            $display("FAIL latency: snd_req=%b one edge after push, required 01", snd_req);
        end
        send(6'd2, 6'd40, 4'd9, 4'd1);
        drain();
        total++;
        if (drop_cnt !== 8'd0 || err_drop !== 1'b0) begin
            bad++;
            $display("FAIL basic_no_drop: drop=%0d err=%b, required 0 0", drop_cnt, err_drop);
        end
    endtask

    task automatic test_priority();
        send(6'd3, 6'd10, 4'd5, 4'd2);
        drain();
    endtask

    task automatic test_full();
        logic blocked;
        max_dly = 0;
        hold[0] = 1'b1;
        for (int i = 0; i < 5; i++) send(6'd4, 6'd5, 4'(i), 4'(15 - i));
        total++;
        if (fifo_full !== 2'b01) begin
            bad++;
            $display("FAIL full_flag: got %b, required 01", fifo_full);
        end
        send(6'd5, 6'd40, 4'd9, 4'd9);
        put_req(6'd6, 6'd5, 4'd5, 4'd10);
        blocked = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (rcv0_ack) blocked = 1'b0;
        end
        total++;
        if (!blocked || fifo_full[0] !== 1'b1) begin
            bad++;
            $display("FAIL full_block: ack_seen=%b full0=%b, required 0 1", !blocked, fifo_full[0]);
        end
        hold[0] = 1'b0;
        finish_req(60);
        drain();
        total++;
        if (fifo_full !== 2'b00) begin
            bad++;
            $display("FAIL full_clear: got %b, required 00", fifo_full);
        end
    endtask

    task automatic test_drop();
        total++;
        if (err_drop !== 1'b0) begin
            bad++;
            $display("FAIL drop_pre: err=%b, required 0", err_drop);
        end
        for (int i = 0; i < 3; i++) send(6'd7, 6'd60, 4'(i), 4'd0);
        total++;
        if (drop_cnt !== 8'(exp_drops) || err_drop !== 1'b1 || exp_drops != 3) begin
            bad++;
            $display("FAIL drop_count: drop=%0d err=%b, required %0d 1", drop_cnt, err_drop, exp_drops);
        end
        total++;
        if (snd_req !== 2'b00) begin
            bad++;
            $display("FAIL drop_no_req: snd_req=%b, required 00", snd_req);
        end
    endtask

    task automatic test_wrap();
        max_dly = 4;
        for (int i = 0; i < 20; i++)
            send(6'($urandom_range(0, 63)), 6'($urandom_range(0, 31)), 4'(i % 16), 4'($urandom_range(0, 15)));
        drain();
    endtask

    task automatic test_reset_mid();
        max_dly = 0;
        hold[1] = 1'b1;
        for (int i = 1; i <= 3; i++) send(6'd8, 6'd40, 4'(i), 4'd3);
        total++;
        if (snd_req !== 2'b10 || snd_dat[7:4] !== 4'd1) begin
            bad++;
            $display("FAIL pre_reset: req=%b dat1=%0d, required 10 1", snd_req, snd_dat[7:4]);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_mid");
        exp_q1.delete();
        hold[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_hold: got %b, required 0", ready);
        end
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_return: got %b, required 1", ready);
        end
        repeat (20) @(negedge clk);
        total++;
        if (snd_req !== 2'b00 || fifo_full !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_quiet: req=%b full=%b, required 00 00", snd_req, fifo_full);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_full();
        test_drop();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
